// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate cache, 8 lines x 4 bytes, in front of a 256x8 byte memory
//   clock/reset                       : system clock, asynchronous active-high reset
//   read/write/address/writedata      : CPU request; address and data held while busywait=1
//   readdata/busywait                 : combinational load data and CPU stall
//   mem_read/mem_write/mem_address/
//   mem_writedata                     : registered byte-wide memory access strobes, address and data
//   mem_readdata/mem_busywait         : memory read data and busy
module data_cache (
    input  logic       clock,
    input  logic       reset,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] address,
    input  logic [7:0] writedata,
    output logic [7:0] readdata,
    output logic       busywait,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_writedata,
    input  logic [7:0] mem_readdata,
    input  logic       mem_busywait
);
    typedef enum logic [2:0] {IDLE, WB_ACCESS, WB_GAP, FETCH_ACCESS, FETCH_GAP, UPDATE} state_t;
    state_t      state_q;
    logic [1:0]  beat_q, beat_d;
    logic        armed_q;
    logic [7:0]  valid_q, dirty_q;
    logic [2:0]  tag_q [8];
    logic [31:0] data_q [8];
    logic        mem_read_q, mem_write_q;
    logic [7:0]  mem_address_q, mem_writedata_q;
    logic [2:0]  tag_in, idx;
    logic [1:0]  off;
    logic        req_rd, req_wr, hit, done;

    assign {tag_in, idx, off} = address;
    assign req_rd = read & ~write;
    assign req_wr = write & ~read;
    assign hit = valid_q[idx] && tag_q[idx] == tag_in;
    assign readdata = hit ? data_q[idx][{off, 3'b000} +: 8] : 8'h00;
    assign busywait = state_q != IDLE || ((req_rd || req_wr) && !hit);
    // armed_q masks the first access cycle so a memory that raises busy late cannot end a beat early
    assign done = armed_q && !mem_busywait;
    assign beat_d = beat_q + 2'd1;
    assign mem_read = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_writedata = mem_writedata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            beat_q          <= 2'd0;
            armed_q         <= 1'b0;
            valid_q         <= 8'h00;
            dirty_q         <= 8'h00;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= 8'h00;
            mem_writedata_q <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((req_rd || req_wr) && !hit) begin
                        beat_q  <= 2'd0;
                        armed_q <= 1'b0;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q         <= WB_ACCESS;
                            mem_write_q     <= 1'b1;
                            mem_address_q   <= {tag_q[idx], idx, 2'd0};
                            mem_writedata_q <= data_q[idx][7:0];
                        end else begin
                            state_q       <= FETCH_ACCESS;
                            mem_read_q    <= 1'b1;
                            mem_address_q <= {tag_in, idx, 2'd0};
                        end
                    end else if (req_wr) begin
                        dirty_q[idx] <= 1'b1;
                    end
                end
                WB_ACCESS: begin
                    armed_q <= 1'b1;
                    if (done) begin
                        mem_write_q <= 1'b0;
                        armed_q     <= 1'b0;
                        beat_q      <= beat_d;
                        state_q     <= WB_GAP;
                    end
                end
                // beat_q has wrapped to 0 once all four beats are done
                WB_GAP: begin
                    if (beat_q == 2'd0) begin
                        state_q       <= FETCH_ACCESS;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= {tag_in, idx, 2'd0};
                    end else begin
                        state_q         <= WB_ACCESS;
                        mem_write_q     <= 1'b1;
                        mem_address_q   <= {tag_q[idx], idx, beat_q};
                        mem_writedata_q <= data_q[idx][{beat_q, 3'b000} +: 8];
                    end
                end
                FETCH_ACCESS: begin
                    armed_q <= 1'b1;
                    if (done) begin
                        mem_read_q <= 1'b0;
                        armed_q    <= 1'b0;
                        beat_q     <= beat_d;
                        state_q    <= FETCH_GAP;
                    end
                end
                FETCH_GAP: begin
                    if (beat_q == 2'd0) begin
                        state_q <= UPDATE;
                    end else begin
                        state_q       <= FETCH_ACCESS;
                        mem_read_q    <= 1'b1;
                        mem_address_q <= {tag_in, idx, beat_q};
                    end
                end
                UPDATE: begin
                    valid_q[idx] <= 1'b1;
                    dirty_q[idx] <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // data and tag arrays are deliberately not reset
    always_ff @(posedge clock) begin
        if (state_q == IDLE && req_wr && hit)
            data_q[idx][{off, 3'b000} +: 8] <= writedata;
        if (state_q == FETCH_ACCESS && done)
            data_q[idx][{beat_q, 3'b000} +: 8] <= mem_readdata;
        if (state_q == UPDATE)
            tag_q[idx] <= tag_in;
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized self-checking bench for data_cache against a behavioural cache model
module tb_data_cache;
    logic       clock = 1'b0, reset = 1'b0, read = 1'b0, write = 1'b0;
    logic [7:0] address = 8'h00, writedata = 8'h00, readdata;
    logic       busywait, mem_read, mem_write;
    logic [7:0] mem_address, mem_writedata;
    logic [7:0] mem_readdata = 8'h00;
    logic       mem_busywait = 1'b0;
    int         n_chk = 0, n_fail = 0;

    data_cache dut (
        .clock(clock), .reset(reset), .read(read), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata), .busywait(busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    // byte memory: busy for 1-3 cycles after a new strobe edge, logs every completed access
    logic [7:0]  mem [256];
    logic [16:0] log_q [$];
    bit          mem_active = 1'b0;
    int          mem_cnt = 0;
    always @(posedge clock) begin
        if (!(mem_read || mem_write)) begin
            mem_active = 1'b0;
            mem_busywait <= 1'b0;
        end else if (!mem_active) begin
            mem_active = 1'b1;
            mem_busywait <= 1'b1;
            mem_cnt = $urandom_range(0, 2);
        end else if (mem_busywait) begin
            if (mem_cnt == 0) begin
                mem_busywait <= 1'b0;
                if (mem_write) begin
                    mem[mem_address] = mem_writedata;
                    log_q.push_back({1'b1, mem_address, mem_writedata});
                end else begin
                    mem_readdata <= mem[mem_address];
                    log_q.push_back({1'b0, mem_address, mem[mem_address]});
                end
            end else begin
                mem_cnt = mem_cnt - 1;
            end
        end
    end

    // reference: what memory should hold and what each cache line should hold
    logic [7:0] ref_mem [256];
    bit         r_valid [8];
    bit         r_dirty [8];
    logic [2:0] r_tag [8];
    logic [7:0] r_data [8][4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic access(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] wd);
        logic [2:0]  x;
        logic [7:0]  exp_rd;
        logic [16:0] exp_q [$];
        bit          legal, miss, dirty_ev;
        int          stall, lo;
        x = a[4:2];
        legal = !(rd && wr);
        miss = legal && !(r_valid[x] && r_tag[x] == a[7:5]);
        dirty_ev = miss && r_valid[x] && r_dirty[x];
        if (dirty_ev)
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back({1'b1, r_tag[x], x, 2'(k), r_data[x][k]});
                ref_mem[{r_tag[x], x, 2'(k)}] = r_data[x][k];
            end
        if (miss) begin
            for (int k = 0; k < 4; k++) begin
                r_data[x][k] = ref_mem[{a[7:5], x, 2'(k)}];
                exp_q.push_back({1'b0, a[7:5], x, 2'(k), r_data[x][k]});
            end
            r_valid[x] = 1'b1;
            r_dirty[x] = 1'b0;
            r_tag[x] = a[7:5];
        end
        if (legal && wr) begin
            r_data[x][a[1:0]] = wd;
            r_dirty[x] = 1'b1;
        end
        exp_rd = r_data[x][a[1:0]];
        log_q.delete();
        read = rd;
        write = wr;
        address = a;
        writedata = wd;
        #1 check("busy_on_request", busywait, miss);
        stall = 0;
        while (busywait && stall < 1000) begin
            @(negedge clock);
            stall++;
        end
        check("no_timeout", stall < 1000, 1);
        if (rd && legal) check("readdata", readdata, exp_rd);
        lo = !miss ? 0 : dirty_ev ? 25 : 13;
        check("stall_cycles", miss ? stall >= lo : stall == 0, 1);
        @(negedge clock);
        check("strobes_idle", mem_read | mem_write, 0);
        read = 1'b0;
        write = 1'b0;
        check("txn_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check("txn", log_q[i], exp_q[i]);
    endtask

    initial begin
        int n, k;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 8; i++) begin
            r_valid[i] = 1'b0;
            r_dirty[i] = 1'b0;
        end
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst_busywait", busywait, 0);
        check("rst_readdata", readdata, 8'h00);
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_mem_address", mem_address, 8'h00);
        check("rst_mem_writedata", mem_writedata, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        access(1, 0, 8'h00, 8'h00);
        check("cold_read_value", r_data[0][0], 8'h10);
        access(1, 0, 8'h03, 8'h00);
        access(0, 1, 8'h02, 8'hAB);
        access(1, 0, 8'h02, 8'h00);
        access(1, 0, 8'h22, 8'h00);
        check("evicted_byte", ref_mem[2], 8'hAB);
        access(1, 0, 8'h02, 8'h00);
        access(1, 1, 8'h02, 8'h55);
        access(1, 0, 8'h02, 8'h00);
        log_q.delete();
        read = 1'b1;
        address = 8'h40;
        n = 0;
        while (!(log_q.size() == 2 && mem_read) && n < 500) begin
            @(negedge clock);
            n++;
        end
        check("third_fetch_beat", n < 500, 1);
        #2 reset = 1'b1;
        #1 check("async_mem_read", mem_read, 0);
        check("async_mem_address", mem_address, 8'h00);
        check("reset_request_misses", busywait, 1);
        @(negedge clock);
        reset = 1'b0;
        read = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r_valid[i] = 1'b0;
            r_dirty[i] = 1'b0;
        end
        access(1, 0, 8'h00, 8'h00);
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            access(k == 0 || k > 4, k < 5, {3'($urandom_range(0, 2)), 5'($urandom)}, 8'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache that sits between the CPU's load/store path and the 256x8-bit byte-wide data memory. On the CPU side it is the responder of the read/write/busywait handshake. On the memory side it is the initiator of that same handshake, moving whole 4-byte blocks as four single-byte memory accesses. Hits complete with no stall; misses stall the CPU through write-back and fetch.

## Interface
- No parameters. Geometry is fixed at 8 lines x 4 bytes.
- Address split: tag = address[7:5], index = address[4:2], offset = address[1:0].
- clock  in  1  system clock; all state changes on the posedge.
- reset  in  1  asynchronous, active-high.
- read  in  1  CPU load request.
- write  in  1  CPU store request.
- address  in  8  CPU byte address; held stable while busywait=1.
- writedata  in  8  CPU store data.
- readdata  out  8  load data; combinational.
- busywait  out  1  CPU stall; combinational.
- mem_read  out  1  memory read strobe; registered.
- mem_write  out  1  memory write strobe; registered.
- mem_address  out  8  memory byte address; registered.
- mem_writedata  out  8  memory write data; registered.
- mem_readdata  in  8  memory read data.
- mem_busywait  in  1  memory busy.

## Operation
- Per-line storage: valid, dirty, 3-bit tag, 32-bit data (byte k = offset k).
- hit = valid[index] && tag[index] == address[7:5].
- readdata = selected byte on a valid hit, else 8'h00.
- read && write both high is illegal and treated as no request: busywait=0, no state change.
- The FSM has states IDLE, WB_ACCESS, WB_GAP, FETCH_ACCESS, FETCH_GAP and UPDATE, plus a 2-bit beat counter.
- **IDLE, read hit:** busywait=0 and readdata is valid in the same cycle.
- **IDLE, write hit:** busywait=0; at the posedge the byte is written and dirty is set.
- **IDLE, miss:** busywait=1 combinationally. At the posedge, beat is set to 0 and the FSM goes to WB_ACCESS if the line is valid and dirty, else to FETCH_ACCESS.
- **WB_ACCESS:**
  - mem_write=1, mem_address={old tag, index, beat}, mem_writedata=line byte[beat].
  - A beat completes on a posedge at least one cycle after strobe assertion where mem_busywait=0.
  - On completion: go to WB_GAP; beat increments and wraps to 0 after 3.
- **WB_GAP:** both strobes low for exactly one cycle. Then go to WB_ACCESS, or to FETCH_ACCESS once 4 beats are done.
- **FETCH_ACCESS:**
  - mem_read=1, mem_address={address[7:5], index, beat}.
  - On completion: mem_readdata is written into line byte[beat], then go to FETCH_GAP.
- **FETCH_GAP:** one cycle with both strobes low. Then go to FETCH_ACCESS, or to UPDATE after beat 3.
- **UPDATE (1 cycle):** tag=address[7:5], valid=1, dirty=0, then return to IDLE. The held request now hits and completes as in IDLE.
- busywait=1 in every state other than IDLE. In IDLE it is 1 only on a miss.
- The gap states are mandatory: the memory detects a new access only on a strobe edge.

## Timing
- **Reset values:** state=IDLE, beat=0, all valid=0, all dirty=0, mem_read=0, mem_write=0, mem_address=0, mem_writedata=0. Data and tag arrays are not cleared.
- **Outputs under reset with no request:** busywait=0, readdata=8'h00.
- **Reset asserted mid-miss:** strobes drop immediately (asynchronous), the FSM goes to IDLE, and all lines are invalidated. A request still present afterwards misses again.
- **Hit latency:** 0 stall cycles.
- **Clean-miss latency:** 4 fetch beats + 4 gap cycles + 1 UPDATE cycle. Each beat lasts ≥2 cycles and is set by the memory.
- **Dirty-miss latency:** 4 write-back beats + 4 gaps are added before the fetch.
- The CPU must not change address, writedata or the request while busywait=1. The cache does not latch them.

## Test plan
- **Cold read miss:** preload mem[0x00..0x03]=0x10,0x11,0x12,0x13, then after reset read 0x00.
  - Required: four mem_read beats at 0x00,0x01,0x02,0x03, each separated by ≥1 cycle with mem_read=0.
  - Required: busywait falls after UPDATE and readdata=0x10.
- **Read hit:** continuing, read 0x03 -> busywait never rises, readdata=0x13 in the same cycle, no memory strobe.
- **Write hit:** write 0xAB to 0x02 -> no memory traffic; a later read of 0x02 returns 0xAB with zero stall.
- **Dirty eviction:** read 0x22 (index 0, tag 1).
  - Required: write-back beats at 0x00..0x03 with data 0x10,0x11,0xAB,0x13, followed by fetch beats at 0x20..0x23.
  - Required: readdata=mem[0x22] once busywait falls.
  - Required: a subsequent read of 0x02 misses, with no write-back because the line is clean.
- **Reset mid-fetch:** assert reset during the third fetch beat.
  - Required: mem_read and mem_address go to 0 without waiting for a clock edge.
  - Required: after release, read 0x00 misses and refetches all 4 bytes.
- **Illegal request:** read=write=1 -> busywait=0, no strobes, line state unchanged.
